// File: rtl/mem_responder.sv
// Single-request memory responder with configurable wait states, byte/half/word
// little-endian access and a one-cycle response pulse. Optional: MEM_RESP_MISALIGN_ERR_EN.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // the initiator holds req_valid and all fields stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        access;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [31:0] lat_wdata;

    logic        e_we;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic        e_uns;
    logic [31:0] e_wdata;

    logic              mis;
    logic              err_c;
    logic [1:0]        boff;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       ext;
    logic [31:0]       rdata_nxt;
    logic [3:0]        lanes;
    logic [31:0]       wdata_rep;
    logic              wr_en;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    assign state_dbg = state;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so the
    // live request fields are used instead of the not-yet-loaded latches.
    always_comb begin
        if (state == S_IDLE) begin
            e_we    = req_we;
            e_addr  = req_addr;
            e_size  = req_size;
            e_uns   = req_unsigned;
            e_wdata = req_wdata;
        end else begin
            e_we    = lat_we;
            e_addr  = lat_addr;
            e_size  = lat_size;
            e_uns   = lat_uns;
            e_wdata = lat_wdata;
        end
    end

    assign access = (state_nxt == S_RESP) && (state != S_RESP);
    assign mis    = ((e_size == 2'b01) && e_addr[0]) || (e_size[1] && (e_addr[1:0] != 2'b00));
    assign idx    = e_addr[ADDR_W+1:2];

`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign err_c = mis;
    assign boff  = e_addr[1:0];
`else
    assign err_c = 1'b0;
    assign boff  = (e_size == 2'b01) ? {e_addr[1], 1'b0} :
                   e_size[1]         ? 2'b00 : e_addr[1:0];
`endif

    assign rd_word = mem[idx];
    assign shifted = rd_word >> {boff, 3'b000};

    always_comb begin
        case (e_size)
            2'b00: begin
                ext       = e_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                lanes     = 4'b0001 << boff;
                wdata_rep = {4{e_wdata[7:0]}};
            end
            2'b01: begin
                ext       = e_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                lanes     = boff[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{e_wdata[15:0]}};
            end
            default: begin
                ext       = rd_word;
                lanes     = 4'b1111;
                wdata_rep = e_wdata;
            end
        endcase
    end

    assign rdata_nxt = (e_we || err_c) ? 32'd0 : ext;
    assign wr_en     = rstn && access && e_we && !err_c;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_size   <= 2'b00;
            lat_uns    <= 1'b0;
            lat_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_size  <= req_size;
                lat_uns   <= req_unsigned;
                lat_wdata <= req_wdata;
                resp_err  <= 1'b0;
            end
            if (access) begin
                resp_rdata <= rdata_nxt;
                resp_err   <= err_c;
            end
        end
    end

    // Upper address bits are deliberately ignored (addresses wrap).
    logic unused_ok;
`ifdef MEM_RESP_MISALIGN_ERR_EN
    assign unused_ok = ^{e_addr[31:ADDR_W+2]};
`else
    assign unused_ok = ^{e_addr[31:ADDR_W+2], mis};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one DUT with two wait states, one with none.
module tb_mem_responder;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  state_dbg;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_req_unsigned = 1'b0;
    logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
    logic [1:0]  z_req_size = 2'b00;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;
    logic [1:0]  z_state_dbg;

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .state_dbg(state_dbg)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_size(z_req_size), .req_unsigned(z_req_unsigned),
        .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err), .state_dbg(z_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the two-wait-state DUT with latency and pulse checks.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        int low;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; low = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin
            if (req_ready === 1'b0) low++;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready === 1'b0) low++;
        check({tag, "_latency"}, lat, 32'd2);
        check({tag, "_ready_low"}, low, 32'd3);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_hold"}, resp_rdata, exp_rdata);
    endtask

    // Full transaction on the zero-wait-state DUT.
    task automatic xact0(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
        int lat;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_size = size;
        z_req_unsigned = uns; z_req_wdata = wdata;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        lat = 0;
        while (z_resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd0);
        check({tag, "_rdata"}, z_resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, z_resp_err}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, z_resp_valid}, 32'd0);
    endtask

    initial begin
        int acc_cnt;
        int rsp_cnt;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        xact("sw20_pre", 1'b1, 32'h20, SZ_W, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        xact("sw10", 1'b1, 32'h10, SZ_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("lw10", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact("lb13", 1'b0, 32'h13, SZ_B, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0);
        xact("lbu13", 1'b0, 32'h13, SZ_B, 1'b1, 32'h0, 32'h0000_00DE, 1'b0);
        xact("lh12", 1'b0, 32'h12, SZ_H, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0);
        xact("lhu10", 1'b0, 32'h10, SZ_H, 1'b1, 32'h0, 32'h0000_BEEF, 1'b0);
        xact("lb10", 1'b0, 32'h10, SZ_B, 1'b0, 32'h0, 32'hFFFF_FFEF, 1'b0);
        xact("sb11", 1'b1, 32'h11, SZ_B, 1'b0, 32'h1234_5655, 32'h0, 1'b0);
        xact("lw10_sb", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0);
        xact("sh12", 1'b1, 32'h12, SZ_H, 1'b0, 32'h0000_CAFE, 32'h0, 1'b0);
        xact("lw10_sh", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hCAFE_55EF, 1'b0);

`ifdef MEM_RESP_MISALIGN_ERR_EN
        xact("lw12_mis", 1'b0, 32'h12, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("sw12_mis", 1'b1, 32'h12, SZ_W, 1'b0, 32'h0BAD_0BAD, 32'h0, 1'b1);
        xact("lh13_mis", 1'b0, 32'h13, SZ_H, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        xact("lw12_force", 1'b0, 32'h12, SZ_W, 1'b0, 32'h0, 32'hCAFE_55EF, 1'b0);
        xact("lh13_force", 1'b0, 32'h13, SZ_H, 1'b0, 32'h0, 32'hFFFF_CAFE, 1'b0);
`endif
        xact("lw10_after", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'hCAFE_55EF, 1'b0);

        // Hold req_valid for two full transaction periods.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = SZ_W;
        req_unsigned = 1'b0;
        acc_cnt = 0; rsp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (req_valid && req_ready) acc_cnt++;
            if (resp_valid) rsp_cnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("hold_accepts", acc_cnt, 32'd2);
        check("hold_resps", rsp_cnt, 32'd2);
        check("hold_rdata", resp_rdata, 32'hCAFE_55EF);
        @(posedge clk); #1;

        // Store dropped by reset while waiting.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = SZ_W;
        req_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid_state_wait", {30'd0, state_dbg}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        check("rstmid_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        rsp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) rsp_cnt++;
        end
        check("rstmid_no_resp", rsp_cnt, 32'd0);
        xact("lw20_after_rst", 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'h0, 1'b0);

        // Zero wait states plus address aliasing.
        xact0("z_sw400", 1'b1, 32'h400, SZ_W, 1'b0, 32'h5A5A_1234, 32'h0);
        xact0("z_lw000", 1'b0, 32'h000, SZ_W, 1'b0, 32'h0, 32'h5A5A_1234);
        xact0("z_lbu401", 1'b0, 32'h401, SZ_B, 1'b1, 32'h0, 32'h0000_0012);
        xact0("z_lh402", 1'b0, 32'h402, SZ_H, 1'b0, 32'h0, 32'h0000_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
